// File: rtl/drm_bus_slave_responder_pkg.sv
// drm_bus_slave_responder: shared bit positions, state type and register map.
// Imported by the responder top and its output slot.
package drm_bus_pkg;

    // Master beat fields (drm_to_uip); DAT is bit 0 in both directions.
    localparam int unsigned DAT    = 0;
    localparam int unsigned WE     = 1;
    localparam int unsigned ADR_LO = 2;
    localparam int unsigned ADR_HI = 3;
    localparam int unsigned CYC    = 4;
    localparam int unsigned CS     = 5;

    // Response beat fields (uip_to_drm).
    localparam int unsigned STA  = 1;
    localparam int unsigned INTR = 2;
    localparam int unsigned ACK  = 3;
    localparam int unsigned PAR  = 4;

    localparam logic [1:0] REG_0   = 2'd0;
    localparam logic [1:0] REG_1   = 2'd1;
    localparam logic [1:0] REG_2   = 2'd2;
    localparam logic [1:0] REG_CNT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD
    } drm_resp_state_t;

endpackage

// File: rtl/drm_bus_slave_responder_if.sv
// drm_bus_slave_responder: AXI4-Stream pair carrying the DRM bus.
// master = activator side, slave = user-IP responder side.
interface drm_bus_if;

    logic        drm_to_uip_tvalid;
    logic [31:0] drm_to_uip_tdata;
    logic        drm_to_uip_tready;
    logic        uip_to_drm_tvalid;
    logic [31:0] uip_to_drm_tdata;
    logic        uip_to_drm_tready;

    modport master (
        output drm_to_uip_tvalid,
        output drm_to_uip_tdata,
        input  drm_to_uip_tready,
        input  uip_to_drm_tvalid,
        input  uip_to_drm_tdata,
        output uip_to_drm_tready
    );

    modport slave (
        input  drm_to_uip_tvalid,
        input  drm_to_uip_tdata,
        output drm_to_uip_tready,
        output uip_to_drm_tvalid,
        output uip_to_drm_tdata,
        input  uip_to_drm_tready
    );

endinterface

// File: rtl/drm_bus_slave_responder_slot.sv
// drm_bus_slave_responder: one-entry response register with valid/ready.
// A load always wins; the entry empties when the consumer takes it.
module drm_bus_resp_slot
    import drm_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic        o_free
);

    logic        r_valid;
    logic [31:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_free  = ~r_valid | i_ready;

endmodule

// File: rtl/drm_bus_slave_responder.sv
// drm_bus_slave_responder: bit-serial DRM bus register endpoint over AXIS.
// Define DRM_RESP_PARITY_EN to drive even parity of bits [3:0] on bit 4.
module drm_bus_slave_responder
    import drm_bus_pkg::*;
#(
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned CNT_W    = 5,
    parameter logic [31:0] REG0_RST = 32'h0,
    parameter logic [31:0] REG1_RST = 32'h0,
    parameter logic [31:0] REG2_RST = 32'h0
) (
    input  logic                  drm_aclk,
    input  logic                  drm_arstn,
    drm_bus_if.slave              bus,
    input  logic                  user_intr,
    output logic [3*WORD_W-1:0]   regs_o,
    output logic [2:0]            word_wr_pulse
);

    drm_resp_state_t    r_state;
    logic               r_we;
    logic [1:0]         r_adr;
    logic [CNT_W-1:0]   r_bitcnt;
    logic [WORD_W-1:0]  r_shreg;
    logic [WORD_W-1:0]  r_snap;
    logic [WORD_W-1:0]  r_reg0;
    logic [WORD_W-1:0]  r_reg1;
    logic [WORD_W-1:0]  r_reg2;
    logic [WORD_W-1:0]  r_cnt;
    logic [2:0]         r_pulse;

    logic               w_free;
    logic               w_acc;
    logic               w_act;
    logic               w_abort;
    logic               w_first;
    logic               w_we_eff;
    logic [1:0]         w_adr_eff;
    logic [CNT_W-1:0]   w_idx;
    logic               w_last;
    logic               w_ro_err;
    logic [WORD_W-1:0]  w_sel_word;
    logic [WORD_W-1:0]  w_rd_word;
    logic [WORD_W-1:0]  w_wr_word;
    logic [31:0]        w_resp;
    logic               w_out_valid;
    logic [31:0]        w_out_data;
    logic               w_unused;

    assign w_unused = ^bus.drm_to_uip_tdata[31:6];

    assign w_acc   = bus.drm_to_uip_tvalid & w_free;
    assign w_act   = w_acc & bus.drm_to_uip_tdata[CYC]
                   & bus.drm_to_uip_tdata[CS];
    assign w_first = (r_state == ST_IDLE);
    assign w_abort = w_acc & ~bus.drm_to_uip_tdata[CYC] & ~w_first;

    // Mid-word we/adr come from the latch, never from the live beat.
    assign w_we_eff  = w_first ? bus.drm_to_uip_tdata[WE] : r_we;
    assign w_adr_eff = w_first ? bus.drm_to_uip_tdata[ADR_HI:ADR_LO]
                               : r_adr;
    assign w_idx     = w_first ? '0 : r_bitcnt;
    assign w_last    = (w_idx == CNT_W'(WORD_W - 1));
    assign w_ro_err  = w_we_eff & w_last & (w_adr_eff == REG_CNT);

    always_comb begin
        w_sel_word = r_cnt;
        unique case (w_adr_eff)
            REG_0:   w_sel_word = r_reg0;
            REG_1:   w_sel_word = r_reg1;
            REG_2:   w_sel_word = r_reg2;
            default: w_sel_word = r_cnt;
        endcase
    end

    assign w_rd_word = w_first ? w_sel_word : r_snap;
    assign w_wr_word = {bus.drm_to_uip_tdata[DAT], r_shreg[WORD_W-1:1]};

    always_comb begin
        w_resp       = '0;
        w_resp[DAT]  = w_ro_err ? 1'b0
                     : (w_we_eff ? bus.drm_to_uip_tdata[DAT]
                                 : w_rd_word[w_idx]);
        w_resp[STA]  = ~w_last;
        w_resp[INTR] = user_intr;
        w_resp[ACK]  = ~w_ro_err;
`ifdef DRM_RESP_PARITY_EN
        w_resp[PAR]  = ^w_resp[ACK:DAT];
`endif
    end

    always_ff @(posedge drm_aclk or negedge drm_arstn) begin
        if (!drm_arstn) begin
            r_state  <= ST_IDLE;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_snap   <= '0;
            r_reg0   <= REG0_RST[WORD_W-1:0];
            r_reg1   <= REG1_RST[WORD_W-1:0];
            r_reg2   <= REG2_RST[WORD_W-1:0];
            r_cnt    <= '0;
            r_pulse  <= '0;
        end else begin
            r_pulse <= '0;
            if (w_abort) begin
                r_state <= ST_IDLE;
            end else if (w_act) begin
                if (w_first) begin
                    r_we   <= bus.drm_to_uip_tdata[WE];
                    r_adr  <= bus.drm_to_uip_tdata[ADR_HI:ADR_LO];
                    r_snap <= w_sel_word;
                end
                r_shreg  <= w_wr_word;
                r_bitcnt <= w_idx + 1'b1;
                if (w_last) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_we_eff) begin
                        unique case (w_adr_eff)
                            REG_0: begin
                                r_reg0     <= w_wr_word;
                                r_pulse[0] <= 1'b1;
                            end
                            REG_1: begin
                                r_reg1     <= w_wr_word;
                                r_pulse[1] <= 1'b1;
                            end
                            REG_2: begin
                                r_reg2     <= w_wr_word;
                                r_pulse[2] <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end else begin
                    r_state <= w_we_eff ? ST_WR : ST_RD;
                end
            end
        end
    end

    drm_bus_resp_slot u_slot (
        .clk     (drm_aclk),
        .rst_n   (drm_arstn),
        .i_load  (w_act),
        .i_data  (w_resp),
        .i_ready (bus.uip_to_drm_tready),
        .o_valid (w_out_valid),
        .o_data  (w_out_data),
        .o_free  (w_free)
    );

    assign bus.drm_to_uip_tready = w_free;
    assign bus.uip_to_drm_tvalid = w_out_valid;
    assign bus.uip_to_drm_tdata  = w_out_data;
    assign regs_o        = {r_reg2, r_reg1, r_reg0};
    assign word_wr_pulse = r_pulse;

endmodule

// File: tb/tb_drm_bus_slave_responder.sv
// drm_bus_slave_responder bench: directed register scenarios then random
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_drm_bus_slave_responder;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        user_intr = 1'b0;
    logic [95:0] regs_o;
    logic [2:0]  pulse;

    drm_bus_if bus ();

    drm_bus_slave_responder dut (
        .drm_aclk      (clk),
        .drm_arstn     (rstn),
        .bus           (bus),
        .user_intr     (user_intr),
        .regs_o        (regs_o),
        .word_wr_pulse (pulse)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Transaction-level model
    bit          m_busy;
    bit          m_we;
    int          m_adr;
    int          m_n;
    logic [31:0] m_word;
    logic [31:0] m_snap;
    logic [31:0] m_reg [4];
    bit          m_ov;
    logic [31:0] m_od;
    logic [2:0]  m_pulse;

    // Accepted responses of the current directed transaction
    int          cap_n;
    logic [31:0] cap_dat, cap_sta, cap_ack, cap_intr;
    logic [31:0] seen_td;
    int          n_pulse1;

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_we    = 1'b0;
        m_adr   = 0;
        m_n     = 0;
        m_word  = '0;
        m_snap  = '0;
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_ov    = 1'b0;
        m_od    = '0;
        m_pulse = '0;
    endfunction

    function automatic void model_clock(input bit v, input logic [31:0] d,
                                        input bit rdy, input bit intr);
        bit          acc, cyc, cs, we, dat, last, rdat, ack;
        int          adr;
        bit          nov;
        logic [31:0] nod;
        acc = v && (!m_ov || rdy);
        nov = m_ov && !rdy;
        nod = m_od;
        m_pulse = '0;
        dat = d[0]; we = d[1]; adr = int'(d[3:2]); cyc = d[4]; cs = d[5];
        if (acc && m_busy && !cyc) begin
            m_busy = 1'b0;
        end else if (acc && cyc && cs) begin
            if (!m_busy) begin
                m_busy = 1'b1; m_we = we; m_adr = adr;
                m_n = 0; m_word = '0; m_snap = m_reg[adr];
            end
            if (m_we) begin
                m_word[m_n] = dat;
                rdat = dat;
            end else begin
                rdat = m_snap[m_n];
            end
            m_n++;
            last = (m_n == W);
            ack = 1'b1;
            if (last && m_we && m_adr == 3) begin
                ack = 1'b0;
                rdat = 1'b0;
            end
            if (last) begin
                m_busy = 1'b0;
                if (m_we && m_adr != 3) begin
                    m_reg[m_adr] = m_word;
                    m_pulse[m_adr] = 1'b1;
                end
                m_reg[3] = m_reg[3] + 32'd1;
            end
            nov = 1'b1;
            nod = '0;
            nod[0] = rdat;
            nod[1] = m_busy;
            nod[2] = intr;
            nod[3] = ack;
`ifdef DRM_RESP_PARITY_EN
            nod[4] = ^nod[3:0];
`endif
        end
        m_ov = nov;
        m_od = nod;
    endfunction

    function automatic logic [31:0] bt(input bit cyc, input bit cs,
                                       input bit we, input logic [1:0] adr,
                                       input bit dat);
        logic [31:0] r;
        r = $urandom();
        r[5:0] = {cs, cyc, adr, we, dat};
        return r;
    endfunction

    task automatic step(input bit v, input logic [31:0] d, input bit rdy,
                        input bit intr);
        @(negedge clk);
        bus.drm_to_uip_tvalid = v;
        bus.drm_to_uip_tdata  = d;
        bus.uip_to_drm_tready = rdy;
        user_intr = intr;
        #1;
        chk("tready", 96'(bus.drm_to_uip_tready), 96'(!m_ov || rdy));
        chk("tvalid", 96'(bus.uip_to_drm_tvalid), 96'(m_ov));
        if (m_ov) chk("tdata", 96'(bus.uip_to_drm_tdata), 96'(m_od));
        chk("regs", regs_o, {m_reg[2], m_reg[1], m_reg[0]});
        chk("pulse", 96'(pulse), 96'(m_pulse));
        seen_td = bus.uip_to_drm_tdata;
        if (pulse == 3'b010) n_pulse1++;
        if (bus.uip_to_drm_tvalid && rdy && cap_n < 32) begin
            cap_dat[cap_n]  = bus.uip_to_drm_tdata[0];
            cap_sta[cap_n]  = bus.uip_to_drm_tdata[1];
            cap_intr[cap_n] = bus.uip_to_drm_tdata[2];
            cap_ack[cap_n]  = bus.uip_to_drm_tdata[3];
            cap_n++;
        end
        @(posedge clk);
        model_clock(v, d, rdy, intr);
    endtask

    task automatic cap_clear();
        cap_n = 0;
        cap_dat = '0; cap_sta = '0; cap_ack = '0; cap_intr = '0;
    endtask

    task automatic xfer(input bit we, input logic [1:0] adr,
                        input logic [31:0] word, input int nbits);
        for (int i = 0; i < nbits; i++)
            step(1'b1, bt(1'b1, 1'b1, we, adr, word[i]), 1'b1, user_intr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, user_intr);
    endtask

    initial begin
        bus.drm_to_uip_tvalid = 1'b0;
        bus.drm_to_uip_tdata  = '0;
        bus.uip_to_drm_tready = 1'b1;
        model_reset();
        cap_clear();
        n_pulse1 = 0;
        idle(2);
        chk("rst_regs", regs_o, 96'h0);
        chk("rst_tvalid", 96'(bus.uip_to_drm_tvalid), 96'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Write reg1
        cap_clear();
        n_pulse1 = 0;
        xfer(1'b1, 2'd1, 32'hA5A5_0F0F, 32);
        idle(2);
        chk("wr1_ack", 96'(cap_ack), 96'hFFFF_FFFF);
        chk("wr1_sta", 96'(cap_sta), 96'h7FFF_FFFF);
        chk("wr1_reg", 96'(regs_o[63:32]), 96'hA5A5_0F0F);
        chk("wr1_pulse_once", 96'(n_pulse1), 96'd1);

        // Read reg1, then the transaction count
        cap_clear();
        xfer(1'b0, 2'd1, '0, 32);
        idle(1);
        chk("rd1_dat", 96'(cap_dat), 96'hA5A5_0F0F);
        cap_clear();
        xfer(1'b0, 2'd3, '0, 32);
        idle(1);
        chk("rd_cnt2", 96'(cap_dat), 96'd2);

        // Abort a reg0 write after 10 bits
        cap_clear();
        xfer(1'b1, 2'd0, 32'hFFFF_FFFF, 10);
        step(1'b1, bt(1'b0, 1'b1, 1'b1, 2'd0, 1'b1), 1'b1, user_intr);
        idle(2);
        chk("abort_nresp", 96'(cap_n), 96'd10);
        chk("abort_reg0", 96'(regs_o[31:0]), 96'h0);
        xfer(1'b1, 2'd0, 32'h1234_5678, 32);
        idle(1);
        chk("wr0_reg", 96'(regs_o[31:0]), 96'h1234_5678);

        // Read reg0 with a 5-cycle response stall mid-word
        cap_clear();
        xfer(1'b0, 2'd0, '0, 12);
        for (int i = 0; i < 5; i++) begin
            logic [31:0] s0;
            step(1'b1, bt(1'b1, 1'b1, 1'b0, 2'd0, 1'b0), 1'b0, user_intr);
            if (i == 0) s0 = seen_td;
            else chk("stall_stable", 96'(seen_td), 96'(s0));
        end
        for (int i = 12; i < 32; i++)
            step(1'b1, bt(1'b1, 1'b1, 1'b0, 2'd0, 1'b0), 1'b1, user_intr);
        idle(1);
        chk("stall_rd0", 96'(cap_dat), 96'h1234_5678);
        chk("stall_nresp", 96'(cap_n), 96'd32);

        // Write to the read-only count register
        cap_clear();
        xfer(1'b1, 2'd3, 32'hFFFF_FFFF, 32);
        idle(1);
        chk("ro_ack", 96'(cap_ack), 96'h7FFF_FFFF);
        chk("ro_dat", 96'(cap_dat), 96'h7FFF_FFFF);
        chk("ro_regs", regs_o, {32'h0, 32'hA5A5_0F0F, 32'h1234_5678});
        cap_clear();
        xfer(1'b0, 2'd3, '0, 32);
        idle(1);
        chk("rd_cnt6", 96'(cap_dat), 96'd6);

        // Interrupt level reflected on responses
        cap_clear();
        user_intr = 1'b1;
        xfer(1'b0, 2'd1, '0, 32);
        idle(1);
        chk("intr_all", 96'(cap_intr), 96'hFFFF_FFFF);
        chk("intr_rd1", 96'(cap_dat), 96'hA5A5_0F0F);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bit v, cyc, cs, rdy, intr;
            v    = ($urandom_range(4) != 0);
            cyc  = ($urandom_range(59) != 0);
            cs   = ($urandom_range(19) != 0);
            rdy  = ($urandom_range(3) != 0);
            intr = ($urandom_range(15) == 0) ? ~user_intr : user_intr;
            step(v, bt(cyc, cs, 1'($urandom()), 2'($urandom()),
                       1'($urandom())), rdy, intr);
        end

        // Reset in the middle of a word
        step(1'b1, bt(1'b0, 1'b1, 1'b0, 2'd0, 1'b0), 1'b1, 1'b0);
        idle(1);
        xfer(1'b1, 2'd2, 32'hFFFF_FFFF, 10);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        model_reset();
        chk("mrst_tvalid", 96'(bus.uip_to_drm_tvalid), 96'h0);
        chk("mrst_regs", regs_o, 96'h0);
        idle(1);
        @(negedge clk);
        rstn = 1'b1;
        xfer(1'b1, 2'd2, 32'hDEAD_BEEF, 32);
        idle(1);
        chk("mrst_wr2", 96'(regs_o[95:64]), 96'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
